// File: rtl/rr_req_queue.sv
// Four-channel request queue bank feeding a 4-way round-robin arbiter.
// Each channel FIFO raises req while non-empty; granted words drain onto one registered output port.

module rr_req_lane #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic              full,
    output logic              req,
    output logic              overflow,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              wr_ok;

    // Flags decode from the registered count only, so a same-cycle pop never frees a slot for a write.
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign req      = (count_q != '0);
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];
    assign wr_ok    = wr_en & ~full;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (wr_en & full);
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr_ok, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

module rr_req_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          wr_en,
    input  logic [4*DATA_W-1:0] wr_data,
    output logic [3:0]          full,
    output logic [3:0]          req,
    input  logic [3:0]          grant,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_src,
    output logic [3:0]          overflow,
    output logic                grant_err
);
    logic [3:0][DATA_W-1:0] lane_rd;
    logic [3:0]             pop;
    logic                   multi;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic [1:0]             out_src_q, out_src_d;
    logic                   grant_err_q, grant_err_d;

    // A grant with two or more bits set is rejected outright: nothing pops anywhere.
    assign multi = |(grant & (grant - 4'd1));
    assign pop   = grant & req & {4{~multi}};

    for (genvar i = 0; i < 4; i++) begin : g_lane
        rr_req_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en[i]),
            .wr_data  (wr_data[i*DATA_W +: DATA_W]),
            .pop      (pop[i]),
            .full     (full[i]),
            .req      (req[i]),
            .overflow (overflow[i]),
            .rd_data  (lane_rd[i])
        );
    end

    always_comb begin
        out_valid_d = |pop;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        grant_err_d = grant_err_q | multi;
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) begin
                out_data_d = lane_rd[i];
                out_src_d  = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            grant_err_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign grant_err = grant_err_q;
endmodule

// File: tb/tb_rr_req_queue.sv
// Randomized scoreboard bench for rr_req_queue: per-channel queue model predicts flags and drained words.

module tb_rr_req_queue;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wr_en = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  grant = '0;
    logic [3:0]  full, req, overflow;
    logic        out_valid, grant_err;
    logic [7:0]  out_data;
    logic [1:0]  out_src;

    rr_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .req(req),
        .grant(grant), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .overflow(overflow), .grant_err(grant_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         stamp;
        logic [1:0] src;
        logic [7:0] data;
    } exp_t;

    typedef logic [7:0] word_q_t [$];

    word_q_t    mq [4];
    exp_t       expq [$];
    logic [3:0] m_ovf = '0;
    logic       m_gerr = 1'b0;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: every visible output must match the oldest expected word due this cycle.
    exp_t       mon_e;
    logic [7:0] last_d = '0;
    logic [1:0] last_s = '0;
    always @(negedge clk) begin
        if (rst) begin
            last_d = '0;
            last_s = '0;
        end else if (out_valid) begin
            tests++;
            if (expq.size() == 0 || expq[0].stamp != cyc) begin
                fails++;
                $display("FAIL spurious_out: got src=%0d data=%h, required no output (cycle %0d)", out_src, out_data, cyc);
            end else begin
                mon_e = expq.pop_front();
                if (out_src !== mon_e.src || out_data !== mon_e.data) begin
                    fails++;
                    $display("FAIL out_word: got src=%0d data=%h, required src=%0d data=%h (cycle %0d)",
                             out_src, out_data, mon_e.src, mon_e.data, cyc);
                end
            end
            last_d = out_data;
            last_s = out_src;
        end else begin
            tests++;
            if (expq.size() != 0 && expq[0].stamp <= cyc) begin
                fails++;
                $display("FAIL missing_out: got out_valid=0, required src=%0d data=%h (cycle %0d)",
                         expq[0].src, expq[0].data, cyc);
                void'(expq.pop_front());
            end else if (out_data !== last_d || out_src !== last_s) begin
                fails++;
                $display("FAIL out_hold: got src=%0d data=%h, required src=%0d data=%h (cycle %0d)",
                         out_src, out_data, last_s, last_d, cyc);
            end
        end
    end

    // One clock of stimulus: check flags against the model, drive inputs, then advance the model.
    task automatic cycle(input logic [3:0] we, input logic [31:0] wd, input logic [3:0] g);
        logic [3:0] mfull, mreq;
        logic       multi;
        exp_t       e;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            mfull[i] = (mq[i].size() == DEPTH);
            mreq[i]  = (mq[i].size() != 0);
        end
        chk("req", {4'b0, req}, {4'b0, mreq});
        chk("full", {4'b0, full}, {4'b0, mfull});
        chk("overflow", {4'b0, overflow}, {4'b0, m_ovf});
        chk("grant_err", {7'b0, grant_err}, {7'b0, m_gerr});
        wr_en   = we;
        wr_data = wd;
        grant   = g;
        multi   = ($countones(g) > 1);
        if (multi) m_gerr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!multi && g[i] && mreq[i]) begin
                e.stamp = cyc + 1;
                e.src   = 2'(i);
                e.data  = mq[i].pop_front();
                expq.push_back(e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                if (mfull[i]) m_ovf[i] = 1'b1;
                else          mq[i].push_back(wd[i*8 +: 8]);
            end
        end
    endtask

    task automatic rand_cycle(input int wp);
        logic [3:0]  we, g;
        logic [31:0] wd;
        int          r, k, k2;
        logic        found;
        for (int i = 0; i < 4; i++) we[i] = ($urandom_range(0, 99) < wp);
        wd = $urandom;
        r  = $urandom_range(0, 99);
        k  = $urandom_range(0, 3);
        if (r < 15) begin
            g = '0;
        end else if (r < 96) begin
            if ($urandom_range(0, 9) < 7) begin
                found = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    if (!found && mq[(k + j) % 4].size() != 0) begin
                        k = (k + j) % 4;
                        found = 1'b1;
                    end
                end
            end
            g = 4'(1) << k;
        end else begin
            k2 = (k + 1 + $urandom_range(0, 2)) % 4;
            g  = (4'(1) << k) | (4'(1) << k2);
        end
        cycle(we, wd, g);
    endtask

    task automatic do_reset();
        cycle(4'h0, 32'h0, 4'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_req", {4'b0, req}, 8'h00);
        chk("rst_full", {4'b0, full}, 8'h00);
        chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_src", {6'b0, out_src}, 8'h00);
        chk("rst_overflow", {4'b0, overflow}, 8'h00);
        chk("rst_grant_err", {7'b0, grant_err}, 8'h00);
        for (int i = 0; i < 4; i++) mq[i].delete();
        expq.delete();
        m_ovf  = '0;
        m_gerr = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #3;
        chk("init_req", {4'b0, req}, 8'h00);
        chk("init_full", {4'b0, full}, 8'h00);
        chk("init_out_valid", {7'b0, out_valid}, 8'h00);
        chk("init_out_data", out_data, 8'h00);
        chk("init_overflow", {4'b0, overflow}, 8'h00);
        chk("init_grant_err", {7'b0, grant_err}, 8'h00);
        @(negedge clk);
        #1 rst = 1'b0;

        // ch0: three words then three granted drains
        cycle(4'h1, 32'h11, 4'h0);
        cycle(4'h1, 32'h22, 4'h0);
        cycle(4'h1, 32'h33, 4'h0);
        repeat (3) cycle(4'h0, 32'h0, 4'h1);
        // ch2: fill, overflow with 0xEE, drain
        cycle(4'h4, 32'h00A1_0000, 4'h0);
        cycle(4'h4, 32'h00A2_0000, 4'h0);
        cycle(4'h4, 32'h00A3_0000, 4'h0);
        cycle(4'h4, 32'h00A4_0000, 4'h0);
        cycle(4'h4, 32'h00EE_0000, 4'h0);
        repeat (5) cycle(4'h0, 32'h0, 4'h4);
        // ch1: two words, grant held past empty
        cycle(4'h2, 32'h0000_B100, 4'h0);
        cycle(4'h2, 32'h0000_B200, 4'h0);
        repeat (4) cycle(4'h0, 32'h0, 4'h2);
        // multi-bit grant with ch0 and ch2 loaded
        cycle(4'h5, 32'h00C2_00C0, 4'h0);
        cycle(4'h0, 32'h0, 4'h5);
        repeat (2) cycle(4'h0, 32'h0, 4'h1);
        cycle(4'h0, 32'h0, 4'h4);
        // ch3: simultaneous write+pop at count 2 across pointer wrap
        cycle(4'h8, 32'hD100_0000, 4'h0);
        cycle(4'h8, 32'hD200_0000, 4'h0);
        cycle(4'h8, 32'hD300_0000, 4'h8);
        cycle(4'h8, 32'hD400_0000, 4'h8);
        cycle(4'h8, 32'hD500_0000, 4'h8);
        cycle(4'h8, 32'hD600_0000, 4'h8);
        repeat (3) cycle(4'h0, 32'h0, 4'h8);
        // empty channel: write and grant together must not pop
        cycle(4'h1, 32'h0000_00E1, 4'h1);
        cycle(4'h0, 32'h0, 4'h1);

        repeat (1500) rand_cycle(55);
        repeat (800) rand_cycle(20);

        // Load all channels with 5 words, drain partway, then reset
        do_reset();
        for (int n = 0; n < 5; n++) cycle(4'hF, $urandom, 4'h0);
        for (int n = 0; n < 6; n++) cycle(4'h0, 32'h0, 4'(1) << (n % 4));
        do_reset();
        repeat (4) cycle(4'h0, 32'h0, 4'hF >> 3);

        repeat (1500) rand_cycle(40);
        repeat (10) cycle(4'h0, 32'h0, 4'h0);
        chk("scoreboard_drained", 8'(expq.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rr_req_queue.md
Name: rr_req_queue

Overview:
Four-channel input queue bank that sits directly upstream of the 4-way round-robin arbiter.
- Each channel buffers write-side data words in its own FIFO.
- Each non-empty FIFO raises req[i] to the arbiter.
- The arbiter returns a one-hot grant; the bank drains one word per granted cycle onto a single shared output port tagged with its source channel.

Parameters:
DATA_W, 8, width of each data word
DEPTH, 4, entries per channel FIFO; must be a power of 2, minimum 2
AW, 2, pointer width, equal to log2(DEPTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
wr_en  input  4  per-channel write strobe
wr_data  input  4*DATA_W  channel i word on bits [i*DATA_W +: DATA_W]
full  output  4  channel i FIFO holds DEPTH words
req  output  4  channel i FIFO non-empty; connects to arbiter req
grant  input  4  one-hot (or zero) grant from arbiter
out_valid  output  1  out_data/out_src valid this cycle
out_data  output  DATA_W  drained word
out_src  output  2  channel index of out_data
overflow  output  4  sticky: write to channel i dropped while full
grant_err  output  1  sticky: grant had more than one bit set

Behaviour:
Reset (async, rst=1):
- All FIFOs empty: rd/wr pointers 0, counts 0.
- full=0, req=0, out_valid=0, out_data=0, out_src=0, overflow=0, grant_err=0.
- Reset mid-operation discards all queued words immediately; no output is produced for them.

Storage and flags:
- Per channel: storage array of DEPTH x DATA_W, wr_ptr/rd_ptr of AW bits, count of AW+1 bits.
- Pointers wrap modulo DEPTH.
- full[i] = (count[i]==DEPTH) and req[i] = (count[i]!=0). Both are decoded combinationally from registered counts, so they are glitch-free relative to clk.

Write:
- Write is accepted on the clk edge when wr_en[i]=1 and full[i]=0: word stored at wr_ptr, wr_ptr+1, count+1.
- wr_en[i]=1 with full[i]=1: word dropped, overflow[i] set and held until reset.
- This applies even if a pop on the same channel occurs in the same cycle; full is evaluated from the registered count.

Pop:
- pop[i] = grant[i] & req[i] & (grant is one-hot).
- On a pop: rd_ptr+1, count-1.

Output timing:
- Output is registered, latency 1. The cycle after pop[i], out_valid=1, out_data = the word at the old rd_ptr, out_src=i.
- In a cycle with no pop, the next cycle has out_valid=0; out_data and out_src hold their last values.

Grant rules:
- grant=0: no pop.
- grant[i]=1 while channel i is empty: no pop, no error, out_valid=0 next cycle. This is the normal case when the arbiter's registered state lags req falling.
- grant with 2 or more bits set: no pop on any channel, grant_err set (sticky), out_valid=0 next cycle.

Simultaneous write and pop on the same channel:
- Both take effect and count is unchanged.
- Empty channel: a write and grant in the same cycle do not pop, because req is 0 that cycle; the word is poppable from the next cycle.

Throughput:
- One word per cycle total.
- The arbiter holds grant up to 4 consecutive cycles per channel while req stays high, so up to 4 words drain back-to-back from one channel.

Test Plan:
- Reset, write 0x11,0x22,0x33 to ch0 over 3 cycles, grant=0001 for 3 cycles -> req[0] high from cycle after first write; out_valid 3 consecutive cycles with out_data 0x11,0x22,0x33, out_src=0; req[0] falls after third pop.
- Fill ch2 with 4 words, then wr_en[2] with 0xEE -> full[2]=1, overflow[2]=1 stays set; drain yields only the 4 original words, never 0xEE.
- ch1 holds 2 words, grant=0010 for 4 cycles -> 2 outputs with out_src=1, then 2 cycles out_valid=0, no underflow, count stays 0.
- grant=0101 with ch0 and ch2 non-empty -> no pop, counts unchanged, grant_err=1, out_valid=0.
- ch3 at count 2, wr_en[3] and grant=1000 in the same cycle -> count stays 2, FIFO order preserved across pointer wrap after 6 total writes and drains.
- Connected to the arbiter, all 4 channels loaded with 5 words, assert rst for one cycle mid-drain -> req=0, out_valid=0, full=0 immediately; no further outputs after rst deasserts.
